pipe_stage_elastic: RTL and testbench
=====================================

// Module: pipe_stage_elastic
// PURPOSE
//  Parametrised, elastic pipeline stage register. Successor to the fixed IF/ID, ID/EX, EX/MEM and MEM/WB registers.
//  Carries a control bundle and a data bundle between two MIPS pipeline stages using valid/ready handshakes.
//  Supports stall (back-pressure), flush (bubble insertion) and an optional 2-entry skid buffer that registers in_ready.
//  An invalid slot always presents CTRL_NOP on out_ctrl, so downstream RF/HI/LO/MEM enables read 0 for a bubble.
// PARAMETERS
//  CTRL_W    16     width of the control bundle (ALU op, enables, mem size, ...)
//  DATA_W    96     width of the data bundle (operands, PC, imm, reg ids)
//  CTRL_NOP  0      control value driven while out_valid=0 and after reset (CTRL_W bits)
//  SKID      1      1: two entries, registered in_ready; 0: one entry, combinational in_ready
// PORTS
//  Clk        in   1       clock, rising edge
//  Reset      in   1       asynchronous, active-high reset
//  in_valid   in   1       upstream holds a valid instruction
//  in_ready   out  1       stage accepts in_* on this edge when in_valid=1
//  in_ctrl    in   CTRL_W  upstream control bundle
//  in_data    in   DATA_W  upstream data bundle
//  flush      in   1       synchronous kill of all held entries and of the same-cycle input
//  out_valid  out  1       main entry is valid
//  out_ready  in   1       downstream consumes the main entry on this edge
//  out_ctrl   out  CTRL_W  main control, or CTRL_NOP when out_valid=0
//  out_data   out  DATA_W  main data; keeps its last value when invalid
//  occupancy  out  2       number of valid entries, 0..2 (0..1 when SKID=0)
// BEHAVIOUR
//  Reset (async): state EMPTY, out_valid=0, out_ctrl=CTRL_NOP, out_data=0, skid=0, occupancy=0, in_ready=1 (SKID=1).
//  Transfers: acc = in_valid & in_ready; pop = out_valid & out_ready. Latency is 1 cycle from in to out when EMPTY.
//  State machine, SKID=1. The state is registered, and in_ready = (state != FULL2).
//   EMPTY: acc -> main<=in, go to FULL1.
//   FULL1: acc&pop -> main<=in, stay. acc&!pop -> skid<=in, go to FULL2. !acc&pop -> EMPTY.
//   FULL2: pop -> main<=skid, go to FULL1. Otherwise hold. No accept is possible in FULL2.
//  SKID=0: single entry. in_ready = !out_valid | out_ready (combinational). EMPTY/FULL1 only, with the same rules.
//  Order is strict FIFO; the skid entry never overtakes main.
//  flush=1 has the highest priority over acc and pop:
//   next state is EMPTY.
//   Same-edge input is dropped, even if in_ready=1.
//   out_ctrl is CTRL_NOP from the next cycle.
//  The pop still completes downstream in the flush cycle; the flush only clears this stage.
//  Reset asserted mid-operation clears the stage immediately, without waiting for a clock edge.
//  Data path registers have no enable other than the load conditions above, so out_data holds through a stall.
//  No X propagation: CTRL_NOP is a constant mux on out_ctrl, not a reset-only value.
// STRUCTURE
//  Shared package mips_pipe_pkg holds:
//   the state enum (EMPTY=2'd0, FULL1=2'd1, FULL2=2'd2);
//   CTRL_NOP constants;
//   per-boundary CTRL_W/DATA_W localparams (IF_ID, ID_EX, EX_MEM, MEM_WB).
//  One natural sub-module: pipe_slot (a {ctrl,data} register with load enable), instantiated for main and skid.
//  The skid slot is generated only when SKID=1.
// TESTING
//  1. Reset mid-stream:
//     stimulus: assert Reset between edges while in FULL2.
//     response: out_valid=0, out_ctrl=CTRL_NOP and occupancy=0 immediately, before any Clk edge.
//  2. Streaming, out_ready=1 held:
//     stimulus: in_data=1,2,3 on consecutive edges.
//     response: out_data=1,2,3 one cycle later; in_ready stays 1; occupancy stays 1.
//  3. Back-pressure, SKID=1:
//     stimulus: out_ready=0 while sending A, then B.
//     response: occupancy=2 and in_ready=0.
//     stimulus: release out_ready.
//     response: A pops, then B pops; nothing is lost or duplicated.
//  4. Flush in FULL2:
//     stimulus: assert flush while presenting C with in_valid=1.
//     response: next cycle out_valid=0, occupancy=0, out_ctrl=CTRL_NOP; C never appears at the output.
//  5. SKID=0 build:
//     stimulus: out_ready=0 with the stage full.
//     response: in_ready=0 in the same cycle.
//     stimulus: out_ready=1.
//     response: in_ready=1 combinationally, and pass-through continues at 1/cycle.
//  6. Bubble check, CTRL_NOP=16'h0000:
//     stimulus: in_valid=0 for 3 cycles.
//     response: out_ctrl=0 each cycle; out_data keeps its last value.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the elastic MIPS pipeline stage registers:
// slot state encoding, bubble control values and per-boundary bundle widths.
package mips_pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL1 = 2'd1,
      FULL2 = 2'd2
   } slot_state_e;

   localparam int          CTRL_W_DEFAULT = 16;
   localparam int          DATA_W_DEFAULT = 96;
   localparam logic [15:0] CTRL_NOP_16    = 16'h0000;

   localparam int IF_ID_CTRL_W  = 16;
   localparam int IF_ID_DATA_W  = 64;
   localparam int ID_EX_CTRL_W  = 16;
   localparam int ID_EX_DATA_W  = 96;
   localparam int EX_MEM_CTRL_W = 16;
   localparam int EX_MEM_DATA_W = 96;
   localparam int MEM_WB_CTRL_W = 16;
   localparam int MEM_WB_DATA_W = 96;

   // The state encoding doubles as the entry count.
   function automatic logic [1:0] slot_count(input slot_state_e s);
      return s;
   endfunction

endpackage

// File: rtl/pipe_slot.sv
// One {ctrl,data} holding register with a load enable; used for both the
// main and the skid entry of pipe_stage_elastic.
module pipe_slot #(
   parameter int W = 8
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic         load_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] slot_q;

   // NOTE: sequential state uses non-blocking assignments only, and this
   // register is cleared by reset so out_data reads 0 before the first load.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         slot_q <= '0;
      end else if (load_i) begin
         slot_q <= d_i;
      end
   end

   assign q_o = slot_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic valid/ready pipeline register between two MIPS stages, with flush
// and an optional skid entry that makes in_ready a registered signal.
module pipe_stage_elastic
   import mips_pipe_pkg::*;
#(
   parameter int                 CTRL_W   = CTRL_W_DEFAULT,
   parameter int                 DATA_W   = DATA_W_DEFAULT,
   parameter logic [CTRL_W-1:0]  CTRL_NOP = '0,
   parameter int                 SKID     = 1
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
);

   localparam int W = CTRL_W + DATA_W;

   slot_state_e  state_q, state_d;
   logic         acc, pop;
   logic         load_main, load_skid, main_from_skid;
   logic [W-1:0] in_word, skid_word, main_d, main_word;

   assign in_word   = {in_ctrl, in_data};
   assign out_valid = (state_q != EMPTY);
   assign in_ready  = (SKID != 0) ? (state_q != FULL2) : (!out_valid || out_ready);
   assign acc       = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   // NOTE: every signal written here gets a default first, so no latch is inferred.
   always_comb begin
      state_d        = state_q;
      load_main      = 1'b0;
      load_skid      = 1'b0;
      main_from_skid = 1'b0;
      case (state_q)
         EMPTY: begin
            if (acc) begin
               load_main = 1'b1;
               state_d   = FULL1;
            end
         end
         FULL1: begin
            if (acc && pop) begin
               load_main = 1'b1;
            end else if (acc) begin
               load_skid = (SKID != 0);
            end else if (pop) begin
               state_d = EMPTY;
            end
         end
         FULL2: begin
            if (pop) begin
               load_main      = 1'b1;
               main_from_skid = 1'b1;
               state_d        = FULL1;
            end
         end
         default: state_d = EMPTY;
      endcase
      if (load_skid) begin
         state_d = FULL2;
      end
      // Flush beats both transfers: the same-edge input is dropped too.
      if (flush) begin
         state_d   = EMPTY;
         load_main = 1'b0;
         load_skid = 1'b0;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   assign main_d = main_from_skid ? skid_word : in_word;

   pipe_slot #(.W(W)) u_main (
      .Clk    (Clk),
      .Reset  (Reset),
      .load_i (load_main),
      .d_i    (main_d),
      .q_o    (main_word)
   );

   generate
      if (SKID != 0) begin : g_skid
         pipe_slot #(.W(W)) u_skid (
            .Clk    (Clk),
            .Reset  (Reset),
            .load_i (load_skid),
            .d_i    (in_word),
            .q_o    (skid_word)
         );
      end else begin : g_no_skid
         assign skid_word = '0;
      end
   endgenerate

   // Bubbles always present CTRL_NOP so downstream enables read inactive.
   assign out_ctrl  = out_valid ? main_word[W-1 -: CTRL_W] : CTRL_NOP;
   assign out_data  = main_word[DATA_W-1:0];
   assign occupancy = slot_count(state_q);

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Self-checking bench: drives a SKID=1 and a SKID=0 instance with shared
// inputs and compares both against queue-based reference models.
module tb_pipe_stage_elastic;

   typedef struct packed {
      logic [15:0] c;
      logic [95:0] d;
   } item_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, flush, out_ready;
   logic [15:0] in_ctrl;
   logic [95:0] in_data;

   logic        s_in_ready, s_out_valid, n_in_ready, n_out_valid;
   logic [15:0] s_out_ctrl, n_out_ctrl;
   logic [95:0] s_out_data, n_out_data;
   logic [1:0]  s_occ, n_occ;

   logic [115:0] obs_s, obs_n, exp_s, exp_n;

   int    n_run  = 0;
   int    n_fail = 0;
   item_t m_s[$];
   item_t m_n[$];
   logic [95:0] last_s, last_n;

   always #5 clk = ~clk;

   pipe_stage_elastic #(.CTRL_W(16), .DATA_W(96), .CTRL_NOP(16'h0000), .SKID(1)) u_skid (
      .Clk(clk), .Reset(rst), .in_valid(in_valid), .in_ready(s_in_ready),
      .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush), .out_valid(s_out_valid),
      .out_ready(out_ready), .out_ctrl(s_out_ctrl), .out_data(s_out_data), .occupancy(s_occ)
   );

   pipe_stage_elastic #(.CTRL_W(16), .DATA_W(96), .CTRL_NOP(16'h0000), .SKID(0)) u_noskid (
      .Clk(clk), .Reset(rst), .in_valid(in_valid), .in_ready(n_in_ready),
      .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush), .out_valid(n_out_valid),
      .out_ready(out_ready), .out_ctrl(n_out_ctrl), .out_data(n_out_data), .occupancy(n_occ)
   );

   // Observation word: {valid, ctrl, data, occupancy, in_ready}
   assign obs_s = {s_out_valid, s_out_ctrl, s_out_data, s_occ, s_in_ready};
   assign obs_n = {n_out_valid, n_out_ctrl, n_out_data, n_occ, n_in_ready};

   function automatic logic [115:0] pack(input logic v, input logic [15:0] c,
                                         input logic [95:0] d, input logic [1:0] o,
                                         input logic r);
      return {v, c, d, o, r};
   endfunction

   task automatic set_in(input logic v, input logic [15:0] c, input logic [95:0] d,
                         input logic ordy, input logic fl);
      in_valid  = v;
      in_ctrl   = c;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
      #1;
   endtask

   task automatic model_reset();
      m_s.delete();
      m_n.delete();
      last_s = '0;
      last_n = '0;
   endtask

   // Advance one clock, updating the FIFO models from the pre-edge inputs.
   task automatic tick();
      item_t it;
      bit    acc_s, acc_n, pop_s, pop_n;
      it    = {in_ctrl, in_data};
      acc_s = in_valid && (m_s.size() < 2);
      acc_n = in_valid && ((m_n.size() == 0) || out_ready);
      pop_s = (m_s.size() != 0) && out_ready;
      pop_n = (m_n.size() != 0) && out_ready;
      @(posedge clk);
      if (flush) begin
         m_s.delete();
         m_n.delete();
      end else begin
         if (pop_s) void'(m_s.pop_front());
         if (acc_s) m_s.push_back(it);
         if (pop_n) void'(m_n.pop_front());
         if (acc_n) m_n.push_back(it);
      end
      if (m_s.size() != 0) last_s = m_s[0].d;
      if (m_n.size() != 0) last_n = m_n[0].d;
      @(negedge clk);
   endtask

   task automatic test_reset();
      #1;
      exp_s = pack(1'b0, 16'h0, 96'h0, 2'd0, 1'b1);
      n_run++;
      if (obs_s !== exp_s) begin
         n_fail++;
         $display("FAIL reset_skid got %h exp %h", obs_s, exp_s);
      end
      n_run++;
      if (obs_n !== exp_s) begin
         n_fail++;
         $display("FAIL reset_noskid got %h exp %h", obs_n, exp_s);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_streaming();
      logic [15:0] c;
      logic [95:0] d;
      for (int k = 1; k <= 3; k++) begin
         c = 16'h0010 + 16'(k);
         d = 96'(k);
         set_in(1'b1, c, d, 1'b1, 1'b0);
         tick();
         exp_s = pack(1'b1, c, d, 2'd1, 1'b1);
         n_run++;
         if (obs_s !== exp_s) begin
            n_fail++;
            $display("FAIL stream_skid_%0d got %h exp %h", k, obs_s, exp_s);
         end
         n_run++;
         if (obs_n !== exp_s) begin
            n_fail++;
            $display("FAIL stream_noskid_%0d got %h exp %h", k, obs_n, exp_s);
         end
      end
      set_in(1'b0, 16'h0, 96'h0, 1'b1, 1'b0);
      tick();
   endtask

   task automatic test_back_pressure();
      set_in(1'b1, 16'h00A1, 96'hA, 1'b0, 1'b0);
      tick();
      set_in(1'b1, 16'h00B2, 96'hB, 1'b0, 1'b0);
      n_run++;
      if (n_in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL noskid_full_ready got %b exp 0", n_in_ready);
      end
      tick();
      exp_s = pack(1'b1, 16'h00A1, 96'hA, 2'd2, 1'b0);
      n_run++;
      if (obs_s !== exp_s) begin
         n_fail++;
         $display("FAIL bp_skid_full2 got %h exp %h", obs_s, exp_s);
      end
      set_in(1'b0, 16'h0, 96'h0, 1'b1, 1'b0);
      n_run++;
      if ({s_in_ready, n_in_ready} !== 2'b01) begin
         n_fail++;
         $display("FAIL bp_release_ready got %b exp 01", {s_in_ready, n_in_ready});
      end
      tick();
      exp_s = pack(1'b1, 16'h00B2, 96'hB, 2'd1, 1'b1);
      exp_n = pack(1'b0, 16'h0, 96'hA, 2'd0, 1'b1);
      n_run++;
      if (obs_s !== exp_s) begin
         n_fail++;
         $display("FAIL bp_pop_a got %h exp %h", obs_s, exp_s);
      end
      n_run++;
      if (obs_n !== exp_n) begin
         n_fail++;
         $display("FAIL bp_noskid_pop got %h exp %h", obs_n, exp_n);
      end
      tick();
      exp_s = pack(1'b0, 16'h0, 96'hB, 2'd0, 1'b1);
      n_run++;
      if (obs_s !== exp_s) begin
         n_fail++;
         $display("FAIL bp_pop_b got %h exp %h", obs_s, exp_s);
      end
   endtask

   task automatic test_flush();
      set_in(1'b1, 16'h00A2, 96'h1A2, 1'b0, 1'b0);
      tick();
      set_in(1'b1, 16'h00B3, 96'h1B3, 1'b0, 1'b0);
      tick();
      set_in(1'b1, 16'h00C4, 96'h1C4, 1'b0, 1'b1);
      tick();
      exp_s = pack(1'b0, 16'h0, 96'h1A2, 2'd0, 1'b1);
      n_run++;
      if (obs_s !== exp_s) begin
         n_fail++;
         $display("FAIL flush_skid got %h exp %h", obs_s, exp_s);
      end
      n_run++;
      if (obs_n !== exp_s) begin
         n_fail++;
         $display("FAIL flush_noskid got %h exp %h", obs_n, exp_s);
      end
      set_in(1'b0, 16'h0, 96'h0, 1'b1, 1'b0);
      tick();
      tick();
      n_run++;
      if (obs_s !== exp_s) begin
         n_fail++;
         $display("FAIL flush_c_dropped got %h exp %h", obs_s, exp_s);
      end
   endtask

   task automatic test_passthrough();
      logic [15:0] c;
      logic [95:0] d;
      for (int k = 0; k < 4; k++) begin
         c = 16'h0100 + 16'(k);
         d = 96'h200 + 96'(k);
         set_in(1'b1, c, d, 1'b1, 1'b0);
         n_run++;
         if (n_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL pass_ready_%0d got %b exp 1", k, n_in_ready);
         end
         tick();
         exp_n = pack(1'b1, c, d, 2'd1, 1'b1);
         n_run++;
         if (obs_n !== exp_n) begin
            n_fail++;
            $display("FAIL pass_noskid_%0d got %h exp %h", k, obs_n, exp_n);
         end
      end
   endtask

   task automatic test_bubble();
      exp_s = pack(1'b0, 16'h0, 96'h203, 2'd0, 1'b1);
      for (int k = 0; k < 3; k++) begin
         set_in(1'b0, 16'hFFFF, {3{32'hDEAD_BEEF}}, 1'b1, 1'b0);
         tick();
         n_run++;
         if (obs_s !== exp_s) begin
            n_fail++;
            $display("FAIL bubble_skid_%0d got %h exp %h", k, obs_s, exp_s);
         end
         n_run++;
         if (obs_n !== exp_s) begin
            n_fail++;
            $display("FAIL bubble_noskid_%0d got %h exp %h", k, obs_n, exp_s);
         end
      end
   endtask

   task automatic test_reset_mid_stream();
      set_in(1'b1, 16'h0D01, 96'h301, 1'b0, 1'b0);
      tick();
      set_in(1'b1, 16'h0D02, 96'h302, 1'b0, 1'b0);
      tick();
      n_run++;
      if (s_occ !== 2'd2) begin
         n_fail++;
         $display("FAIL rst_mid_setup got %0d exp 2", s_occ);
      end
      set_in(1'b0, 16'h0, 96'h0, 1'b0, 1'b0);
      #1 rst = 1'b1;
      #1;
      exp_s = pack(1'b0, 16'h0, 96'h0, 2'd0, 1'b1);
      n_run++;
      if (obs_s !== exp_s) begin
         n_fail++;
         $display("FAIL rst_mid_async got %h exp %h", obs_s, exp_s);
      end
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         set_in(1'($urandom_range(0, 1)), 16'($urandom), {$urandom, $urandom, $urandom},
                $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
         exp_s = pack(m_s.size() != 0, (m_s.size() != 0) ? m_s[0].c : 16'h0, last_s,
                      2'(m_s.size()), m_s.size() < 2);
         exp_n = pack(m_n.size() != 0, (m_n.size() != 0) ? m_n[0].c : 16'h0, last_n,
                      2'(m_n.size()), (m_n.size() == 0) || out_ready);
         n_run++;
         if (obs_s !== exp_s) begin
            n_fail++;
            $display("FAIL rand_skid_%0d got %h exp %h", i, obs_s, exp_s);
         end
         n_run++;
         if (obs_n !== exp_n) begin
            n_fail++;
            $display("FAIL rand_noskid_%0d got %h exp %h", i, obs_n, exp_n);
         end
         tick();
      end
   endtask

   initial begin
      rst = 1'b0;
      set_in(1'b0, 16'h0, 96'h0, 1'b0, 1'b0);
      #1 rst = 1'b1;
      test_reset();
      test_streaming();
      test_back_pressure();
      test_flush();
      test_passthrough();
      test_bubble();
      test_reset_mid_stream();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
